// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - parametrised single-clock FIFO with thresholds, sticky errors, flush and FWFT
module fifo_sync_param #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2,
  parameter int FWFT       = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           w_en,
  input  logic [DATA_WIDTH-1:0]          data_in,
  input  logic                           r_en,
  output logic [DATA_WIDTH-1:0]          data_out,
  output logic                           rd_valid,
  output logic                           full,
  output logic                           empty,
  output logic                           almost_full,
  output logic                           almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  input  logic                           flush,
  input  logic                           clr_err,
  output logic                           overflow,
  output logic                           underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  rd_acc, wr_acc;

  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  // A read frees a slot in the same cycle, so a full FIFO still accepts a paired write.
  always_comb begin
    rd_acc   = r_en && !empty && !flush;
    wr_acc   = w_en && (!full || rd_acc) && !flush;
    wr_ptr_d = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
    ovf_d = (ovf_q && !clr_err) || (w_en && !wr_acc && !flush);
    udf_d = (udf_q && !clr_err) || (r_en && !rd_acc && !flush);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is shown directly; forced to zero while empty so stale memory never leaks out.
      assign rd_valid = !empty;
      assign data_out = empty ? '0 : mem_q[rd_ptr_q];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q;
      logic                  rv_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          dout_q <= '0;
          rv_q   <= 1'b0;
        end else begin
          rv_q <= rd_acc;
          if (rd_acc) begin
            dout_q <= mem_q[rd_ptr_q];
          end
        end
      end

      assign rd_valid = rv_q;
      assign data_out = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb/tb_fifo_sync_param.sv - self-checking bench for fifo_sync_param (standard and FWFT instances)
module tb_fifo_sync_param;

  logic        clk = 1'b0;
  logic        rst, w_en, r_en, flush, clr_err;
  logic [31:0] data_in;

  logic [31:0] dout0, dout1;
  logic        rv0, full0, empty0, af0, ae0, ovf0, udf0;
  logic        rv1, full1, empty1, af1, ae1, ovf1, udf1;
  logic [3:0]  cnt0, cnt1;

  int passed = 0;
  int total  = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  fifo_sync_param #(.DATA_WIDTH(32), .DEPTH(8), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(dout0), .rd_valid(rv0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(cnt0), .flush(flush),
    .clr_err(clr_err), .overflow(ovf0), .underflow(udf0)
  );

  fifo_sync_param #(.DATA_WIDTH(32), .DEPTH(8), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(dout1), .rd_valid(rv1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(cnt1), .flush(flush),
    .clr_err(clr_err), .overflow(ovf1), .underflow(udf1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a queue of stored words plus the last popped word.
  logic [31:0] q[$];
  logic [31:0] m_dout;
  bit          m_rv, m_ovf, m_udf, rd_ok, wr_ok;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_dout = 32'h0;
      m_rv   = 1'b0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else begin
      if (clr_err) begin
        m_ovf = 1'b0;
        m_udf = 1'b0;
      end
      if (flush) begin
        q.delete();
        m_rv = 1'b0;
      end else begin
        rd_ok = r_en && (q.size() > 0);
        wr_ok = w_en && ((q.size() < 8) || rd_ok);
        m_rv  = rd_ok;
        if (rd_ok) m_dout = q.pop_front();
        if (wr_ok) q.push_back(data_in);
        if (w_en && !wr_ok) m_ovf = 1'b1;
        if (r_en && !rd_ok) m_udf = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_count",  {28'h0, cnt0},  q.size());
      check("m_full",   {31'h0, full0}, (q.size() == 8) ? 1 : 0);
      check("m_empty",  {31'h0, empty0}, (q.size() == 0) ? 1 : 0);
      check("m_afull",  {31'h0, af0},   (q.size() >= 6) ? 1 : 0);
      check("m_aempty", {31'h0, ae0},   (q.size() <= 2) ? 1 : 0);
      check("m_ovf",    {31'h0, ovf0},  {31'h0, m_ovf});
      check("m_udf",    {31'h0, udf0},  {31'h0, m_udf});
      check("m_rv_std", {31'h0, rv0},   {31'h0, m_rv});
      check("m_do_std", dout0,          m_dout);
      check("m_count_f", {28'h0, cnt1}, q.size());
      check("m_flags_f", {26'h0, full1, empty1, af1, ae1, ovf1, udf1},
            {26'h0, 1'(q.size() == 8), 1'(q.size() == 0), 1'(q.size() >= 6),
             1'(q.size() <= 2), m_ovf, m_udf});
      check("m_rv_fwft", {31'h0, rv1},  (q.size() > 0) ? 1 : 0);
      check("m_do_fwft", dout1,         (q.size() > 0) ? q[0] : 32'h0);
    end
  end

  task automatic cyc(input bit w, input logic [31:0] d, input bit r, input bit fl, input bit ce);
    w_en = w; data_in = d; r_en = r; flush = fl; clr_err = ce;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] wrap_exp [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; w_en = 0; r_en = 0; flush = 0; clr_err = 0; data_in = 0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    check("rst_count", {28'h0, cnt0}, 0);
    check("rst_empty", {31'h0, empty0}, 1);
    check("rst_ae",    {31'h0, ae0}, 1);
    check("rst_af",    {31'h0, af0}, 0);
    check("rst_full",  {31'h0, full0}, 0);
    check("rst_rv",    {31'h0, rv0}, 0);
    check("rst_dout",  dout0, 0);
    check("rst_errs",  {30'h0, ovf0, udf0}, 0);
    check("rst_fwft",  {dout1[30:0], rv1}, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      cyc(1, 32'h11 + i, 0, 0, 0);
      check("fill_af", {31'h0, af0}, (i + 1 >= 6) ? 1 : 0);
    end
    check("fill_full", {31'h0, full0}, 1);
    check("fill_count", {28'h0, cnt0}, 8);
    cyc(1, 32'h99, 0, 0, 0);
    check("ovf_set", {31'h0, ovf0}, 1);
    check("ovf_count", {28'h0, cnt0}, 8);
    cyc(0, 0, 0, 0, 1);
    check("ovf_clr", {31'h0, ovf0}, 0);

    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1, 0, 0);
      check("drain_data", dout0, 32'h11 + i);
      check("drain_rv", {31'h0, rv0}, 1);
      check("drain_ae", {31'h0, ae0}, (7 - i <= 2) ? 1 : 0);
    end
    check("drain_empty", {31'h0, empty0}, 1);
    cyc(0, 0, 0, 0, 0);
    check("rv_one_cycle", {31'h0, rv0}, 0);
    check("dout_hold", dout0, 32'h18);

    cyc(0, 0, 1, 0, 0);
    check("udf_set", {31'h0, udf0}, 1);
    check("udf_rv", {31'h0, rv0}, 0);
    cyc(0, 0, 0, 0, 1);
    check("udf_clr", {31'h0, udf0}, 0);

    for (int i = 0; i < 8; i++) cyc(1, 32'h11 + i, 0, 0, 0);
    cyc(1, 32'hAA, 1, 0, 0);
    check("rw_full_count", {28'h0, cnt0}, 8);
    check("rw_full_ovf", {31'h0, ovf0}, 0);
    check("rw_full_dout", dout0, 32'h11);
    wrap_exp = '{32'h12, 32'h13, 32'h14, 32'h15, 32'h16, 32'h17, 32'h18, 32'hAA};
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1, 0, 0);
      check("wrap_data", dout0, wrap_exp[i]);
    end

    cyc(1, 32'h5A, 0, 0, 0);
    check("fwft_first", dout1, 32'h5A);
    check("fwft_rv", {31'h0, rv1}, 1);
    cyc(1, 32'h5B, 0, 0, 0);
    check("fwft_hold", dout1, 32'h5A);
    cyc(0, 0, 1, 0, 0);
    check("fwft_next", dout1, 32'h5B);
    check("fwft_rv2", {31'h0, rv1}, 1);
    cyc(0, 0, 1, 0, 0);
    check("fwft_empty_rv", {31'h0, rv1}, 0);

    for (int i = 0; i < 6; i++) cyc(1, 32'h30 + i, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    check("pre_flush_count", {28'h0, cnt0}, 5);
    check("pre_flush_rv", {31'h0, rv0}, 1);
    cyc(1, 32'h77, 0, 1, 0);
    check("flush_count", {28'h0, cnt0}, 0);
    check("flush_empty", {31'h0, empty0}, 1);
    check("flush_rv", {30'h0, rv0, rv1}, 0);
    check("flush_errs", {30'h0, ovf0, udf0}, 0);

    cyc(0, 0, 1, 0, 1);
    check("set_wins", {31'h0, udf0}, 1);
    cyc(0, 0, 0, 0, 1);
    check("set_wins_clr", {31'h0, udf0}, 0);

    for (int i = 0; i < 3; i++) cyc(1, 32'h40 + i, (i == 2), 0, 0);
    rst = 1'b1;
    cyc(1, 32'h50, 0, 0, 0);
    check("mid_rst_count", {28'h0, cnt0}, 0);
    check("mid_rst_flags", {28'h0, empty0, ae0, af0, full0}, 4'b1100);
    check("mid_rst_rv", {30'h0, rv0, rv1}, 0);
    check("mid_rst_dout", dout0, 0);
    check("mid_rst_dout_f", dout1, 0);
    rst = 1'b0;
    cyc(1, 32'h41, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    check("post_rst_data", dout0, 32'h41);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
